// File: rtl/speed_sample_sequencer.sv
// rtl/speed_sample_sequencer.sv - sample strobe, settle discard and result capture for the speed datapath
// Optional watchdog is compiled in with SPEED_SEQ_WATCHDOG_EN.
module speed_sample_sequencer #(
  parameter int DIV_W  = 16,
  parameter int N      = 6,
  parameter int SETTLE = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic             sample,
  output logic             dp_reset,
  input  logic             dp_ready,
  input  logic [15:0]      dp_speed,
  output logic [15:0]      speed,
  output logic             valid,
  input  logic             ack,
  output logic             overrun,
  input  logic             clr_overrun,
  output logic             busy,
  output logic             fault
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_SETTLE, S_RUN} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_next;
  logic [SW-1:0]    r_settle;
  logic             r_ready_d;
  logic             r_sample;
  logic             r_dp_reset;
  logic             r_busy;
  logic             r_valid;
  logic             r_overrun;
  logic [15:0]      r_speed;
  logic             w_event;
  logic             w_active;
  logic             w_next_active;
  logic             w_sample_next;
  logic             w_ovr_set;
  logic             w_wd_trip;

  if (N < 1 || N > 24) begin : g_bad_n
    $error("speed_sample_sequencer: N out of range");
  end

  assign w_event  = dp_ready && !r_ready_d;
  assign w_active = (r_state == S_SETTLE) || (r_state == S_RUN);

`ifdef SPEED_SEQ_WATCHDOG_EN
  localparam int WW = N + 2;
  localparam logic [WW-1:0] WD_LIMIT = WW'((1 << N) + 2);

  logic [WW-1:0] r_wd_cnt;
  logic          r_fault;

  // Trips on the strobe that would make the count reach the limit with no result alongside it.
  assign w_wd_trip = w_active && r_sample && !w_event && ((r_wd_cnt + WW'(1)) == WD_LIMIT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wd_cnt <= '0;
      r_fault  <= 1'b0;
    end else begin
      if (!w_active || w_event || w_wd_trip)
        r_wd_cnt <= '0;
      else if (r_sample)
        r_wd_cnt <= r_wd_cnt + WW'(1);
      if (w_wd_trip)
        r_fault <= 1'b1;
    end
  end

  assign fault = r_fault;
`else
  assign w_wd_trip = 1'b0;
  assign fault     = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (enable) w_next = S_FLUSH;
      S_FLUSH: begin
        if (!enable)          w_next = S_IDLE;
        else if (SETTLE == 0) w_next = S_RUN;
        else                  w_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (!enable)                                 w_next = S_IDLE;
        else if (w_wd_trip)                          w_next = S_FLUSH;
        else if (w_event && r_settle == SETTLE_LAST) w_next = S_RUN;
      end
      S_RUN: begin
        if (!enable)        w_next = S_IDLE;
        else if (w_wd_trip) w_next = S_FLUSH;
      end
      default: w_next = S_IDLE;
    endcase

    // The counter holds the period position of the coming cycle, so the strobe can be registered.
    w_next_active = (w_next == S_SETTLE) || (w_next == S_RUN);
    w_cnt_next    = (w_active && !r_sample) ? r_cnt + DIV_W'(1) : '0;
    w_sample_next = w_next_active && (w_cnt_next >= div);
    w_ovr_set     = (r_state == S_RUN) && w_event && r_valid && !ack;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_settle   <= '0;
      r_ready_d  <= 1'b0;
      r_sample   <= 1'b0;
      r_dp_reset <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt_next;
      r_sample   <= w_sample_next;
      r_dp_reset <= !w_next_active;
      r_busy     <= (r_state != S_IDLE);
      r_ready_d  <= (r_state == S_FLUSH) ? 1'b0 : dp_ready;
      if (r_state == S_FLUSH)
        r_settle <= '0;
      else if (r_state == S_SETTLE && w_event)
        r_settle <= r_settle + SW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_speed   <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (r_state == S_RUN && w_event && (!r_valid || ack)) begin
        r_speed <= dp_speed;
        r_valid <= 1'b1;
      end else if (ack) begin
        r_valid <= 1'b0;
      end
      r_overrun <= w_ovr_set || (r_overrun && !clr_overrun);
    end
  end

  assign sample   = r_sample;
  assign dp_reset = r_dp_reset;
  assign speed    = r_speed;
  assign valid    = r_valid;
  assign overrun  = r_overrun;
  assign busy     = r_busy;

endmodule

// File: tb/tb_speed_sample_sequencer.sv
// tb/tb_speed_sample_sequencer.sv - directed self-checking bench for speed_sample_sequencer
module tb_speed_sample_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] div;
  logic        sample;
  logic        dp_reset;
  logic        dp_ready;
  logic [15:0] dp_speed;
  logic [15:0] speed;
  logic        valid;
  logic        ack;
  logic        overrun;
  logic        clr_overrun;
  logic        busy;
  logic        fault;

  int total = 0;
  int bad   = 0;
  int n_samp;
  logic got_fault;

  always #5 clock = ~clock;

  speed_sample_sequencer #(.DIV_W(16), .N(6), .SETTLE(2)) dut (
    .clock(clock), .reset(reset), .enable(enable), .div(div),
    .sample(sample), .dp_reset(dp_reset), .dp_ready(dp_ready), .dp_speed(dp_speed),
    .speed(speed), .valid(valid), .ack(ack), .overrun(overrun),
    .clr_overrun(clr_overrun), .busy(busy), .fault(fault)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Raises dp_ready for one cycle; outputs checked afterwards reflect that result event.
  task automatic event_pulse(input logic [15:0] v, input logic a);
    dp_ready = 1'b1;
    dp_speed = v;
    ack      = a;
    tick;
    ack      = 1'b0;
    dp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; div = 16'd3; dp_ready = 1'b0;
    dp_speed = 16'h0; ack = 1'b0; clr_overrun = 1'b0;
    tick; tick;
    check("rst_sample",   {15'b0, sample},   16'h0);
    check("rst_dp_reset", {15'b0, dp_reset}, 16'h1);
    check("rst_speed",    speed,             16'h0);
    check("rst_valid",    {15'b0, valid},    16'h0);
    check("rst_overrun",  {15'b0, overrun},  16'h0);
    check("rst_busy",     {15'b0, busy},     16'h0);
    check("rst_fault",    {15'b0, fault},    16'h0);
    reset = 1'b1;
    tick;

    enable = 1'b1;
    tick;
    check("flush_dp_reset", {15'b0, dp_reset}, 16'h1);
    tick;
    check("run_dp_reset", {15'b0, dp_reset}, 16'h0);
    check("run_busy",     {15'b0, busy},     16'h1);
    check("sample_t2",    {15'b0, sample},   16'h0);
    for (int k = 3; k <= 9; k++) begin
      tick;
      check($sformatf("sample_t%0d", k), {15'b0, sample}, (k == 5 || k == 9) ? 16'h1 : 16'h0);
    end

    event_pulse(16'h0111, 1'b0);
    check("settle1_valid", {15'b0, valid}, 16'h0);
    tick;
    event_pulse(16'h0222, 1'b0);
    check("settle2_valid", {15'b0, valid}, 16'h0);
    tick;
    event_pulse(16'h0400, 1'b0);
    check("first_valid", {15'b0, valid}, 16'h1);
    check("first_speed", speed, 16'h0400);
    tick;
    ack = 1'b1;
    tick;
    ack = 1'b0;
    check("ack_valid", {15'b0, valid}, 16'h0);

    event_pulse(16'h0100, 1'b0);
    check("ovr_speed_a", speed, 16'h0100);
    tick;
    event_pulse(16'h0200, 1'b0);
    check("ovr_speed_b", speed, 16'h0100);
    check("ovr_flag",    {15'b0, overrun}, 16'h1);
    check("ovr_valid",   {15'b0, valid},   16'h1);
    tick;
    clr_overrun = 1'b1;
    tick;
    clr_overrun = 1'b0;
    check("ovr_clear", {15'b0, overrun}, 16'h0);

    event_pulse(16'h0300, 1'b1);
    check("simul_valid",   {15'b0, valid},   16'h1);
    check("simul_speed",   speed,            16'h0300);
    check("simul_overrun", {15'b0, overrun}, 16'h0);
    tick;

    clr_overrun = 1'b1;
    event_pulse(16'h0500, 1'b0);
    clr_overrun = 1'b0;
    check("setwins_overrun", {15'b0, overrun}, 16'h1);
    check("setwins_speed",   speed,            16'h0300);
    tick;
    clr_overrun = 1'b1;
    tick;
    clr_overrun = 1'b0;
    check("setwins_clear", {15'b0, overrun}, 16'h0);

    enable = 1'b0;
    tick;
    check("dis_dp_reset", {15'b0, dp_reset}, 16'h1);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("dis_sample%0d", k), {15'b0, sample}, 16'h0);
      tick;
    end
    check("dis_busy",  {15'b0, busy},  16'h0);
    check("dis_valid", {15'b0, valid}, 16'h1);
    event_pulse(16'h0600, 1'b0);
    tick;
    check("idle_evt_speed", speed, 16'h0300);
    check("idle_evt_valid", {15'b0, valid}, 16'h1);
    ack = 1'b1;
    tick;
    ack = 1'b0;
    check("idle_ack_valid", {15'b0, valid}, 16'h0);

    enable = 1'b1;
    tick;
    check("reflush_dp_reset", {15'b0, dp_reset}, 16'h1);
    tick;
    check("rerun_dp_reset", {15'b0, dp_reset}, 16'h0);
    event_pulse(16'h0700, 1'b0);
    check("resettle1_valid", {15'b0, valid}, 16'h0);
    tick;
    event_pulse(16'h0710, 1'b0);
    check("resettle2_valid", {15'b0, valid}, 16'h0);
    tick;
    event_pulse(16'h0720, 1'b0);
    check("rerun_valid", {15'b0, valid}, 16'h1);
    check("rerun_speed", speed, 16'h0720);
    tick;

    div = 16'd0;
    for (int k = 0; k < 3; k++) begin
      tick;
      check($sformatf("div0_sample%0d", k), {15'b0, sample}, 16'h1);
    end

    #2;
    reset = 1'b0;
    #1;
    check("arst_sample",   {15'b0, sample},   16'h0);
    check("arst_dp_reset", {15'b0, dp_reset}, 16'h1);
    check("arst_valid",    {15'b0, valid},    16'h0);
    check("arst_speed",    speed,             16'h0);
    check("arst_busy",     {15'b0, busy},     16'h0);
    enable = 1'b0;
    tick;
    reset = 1'b1;
    tick;

    enable = 1'b1;
    tick;
    n_samp = 0;
    got_fault = 1'b0;
    for (int k = 0; k < 80; k++) begin
      tick;
      if (fault) begin
        got_fault = 1'b1;
        break;
      end
      if (sample) n_samp++;
    end
`ifdef SPEED_SEQ_WATCHDOG_EN
    check("wd_fault",    {15'b0, got_fault}, 16'h1);
    check("wd_samples",  n_samp[15:0],       16'd66);
    check("wd_dp_reset", {15'b0, dp_reset},  16'h1);
`else
    check("wd_off_fault",   {15'b0, got_fault}, 16'h0);
    check("wd_off_samples", n_samp[15:0],       16'd80);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/speed_sample_sequencer.md
# speed_sample_sequencer

Controller for the phase-averaging/speed-scaling datapath in the Hilbert filter chain. Generates the datapath's `sample` strobe at a programmable decimation rate and holds the datapath in reset while disabled. Discards the first averages after start-up while the filter settles, then captures each speed result into a valid/ack output register. Flags overruns when a consumer does not drain results in time.

## Interface
Parameters:
- `DIV_W`, 16: width of the sample-period divider.
- `N`, 6: log2 of the datapath's averaging length; used only by the optional watchdog.
- `SETTLE`, 2: number of datapath results discarded after each start; 0 is legal.

Ports:
- `clock`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run request, level-sensitive.
- `div`  in  DIV_W  sample period minus 1, in clocks.
- `sample`  out  1  one-cycle strobe to the datapath.
- `dp_reset`  out  1  synchronous active-high reset to the datapath.
- `dp_ready`  in  1  datapath ready level.
- `dp_speed`  in  16  signed 6Q10 speed from the datapath; valid while `dp_ready` is high.
- `speed`  out  16  signed 6Q10 captured speed.
- `valid`  out  1  `speed` holds an unconsumed result.
- `ack`  in  1  consumer accepts `speed`; meaningful only while `valid` is high.
- `overrun`  out  1  sticky flag: a result was dropped.
- `clr_overrun`  in  1  clears `overrun`.
- `busy`  out  1  high in any state other than IDLE.
- `fault`  out  1  sticky watchdog flag; tied 0 when the watchdog is compiled out.

## Operation
- States: IDLE, FLUSH, SETTLE, RUN.
- IDLE:
  - `dp_reset`=1, `sample`=0.
  - Goes to FLUSH when `enable`=1.
- FLUSH: lasts one cycle, with `dp_reset`=1.
  - Clears the divider counter, settle counter and edge-detect register.
  - Next state is SETTLE, or RUN when `SETTLE`=0.
- SETTLE and RUN:
  - `dp_reset`=0.
  - Divider counter `cnt` increments each cycle.
  - When `cnt`==`div`: `sample`=1 for that cycle and `cnt`←0.
  - `div` is compared live, so a change takes effect within the current period. If `cnt`>`div` after a change, `sample` fires and `cnt`←0.
  - `div`=0 gives a sample every cycle.
- Result event: `dp_ready`=1 while the previous cycle's `dp_ready`=0 (rising edge). `dp_speed` is sampled in that cycle.
- In SETTLE, each result event increments the settle counter and the result is discarded. On the `SETTLE`-th event, go to RUN.
- In RUN, on a result event:
  - If `valid`=0, or `ack`=1 in the same cycle: `speed`←`dp_speed`, `valid`←1.
  - Otherwise `speed` is kept, the new result is dropped, and `overrun`←1.
- `ack` while `valid`=1 with no result event: `valid`←0.
- `overrun` set and `clr_overrun` in the same cycle: set wins.
- `enable`=0 in any non-IDLE state: go to IDLE next cycle.
  - `sample` stops immediately.
  - `speed`/`valid` are retained until acked.
  - Result events in IDLE/FLUSH are ignored.
- `enable` re-asserted: always passes through FLUSH and SETTLE again.
- Reset values: state IDLE, `sample`=0, `dp_reset`=1, `speed`=0, `valid`=0, `overrun`=0, `busy`=0, `fault`=0, all counters 0.
- Reset asserted mid-operation: all of the above apply immediately (asynchronous reset); an in-flight result is lost.

## Timing
- `enable` rises in cycle t (state IDLE):
  - FLUSH in t+1.
  - SETTLE/RUN from t+2.
  - First `sample` in cycle t+2+`div`.
- `sample` is registered: it is high in the cycle after the counter reaches `div`.
- Result event in cycle t: `speed`/`valid` update at t+1.
- `ack` in cycle t: `valid` low at t+1, unless a result event also occurs in cycle t.
- `busy` is registered from state: it rises one cycle after IDLE is left.

## Configuration
- `SPEED_SEQ_WATCHDOG_EN` defined:
  - In SETTLE/RUN, a counter tracks `sample` strobes since the last result event, or since FLUSH.
  - The counter reaches 2^N+2 when `sample` fires with no result event in the same cycle. When that happens: `fault`←1 (sticky, cleared only by reset), the FSM goes to FLUSH, and the counter clears.
- Not defined: no watchdog counter is built and `fault` is a constant 0.

## Test plan
- Start-up: reset, `div`=3, `SETTLE`=2, `enable`=1 at cycle 10.
  - `dp_reset` falls at cycle 12.
  - `sample` strobes at 15, 19, 23, …
  - The first two `dp_ready` rising edges produce no `valid`.
  - The third edge, with `dp_speed`=16'h0400, gives `valid`=1 and `speed`=16'h0400 one cycle later.
- Overrun: hold `ack`=0 across two RUN result events (0x0100, then 0x0200).
  - `speed` stays 0x0100 and `overrun`=1.
  - Pulse `clr_overrun`: `overrun`=0 on the next cycle.
- Simultaneous ack and event: `valid`=1 with `speed`=0x0100; `ack`=1 in the same cycle as a result event with 0x0300.
  - Next cycle: `valid`=1, `speed`=0x0300, `overrun`=0.
- Disable mid-run: drop `enable` while `valid`=1.
  - Next cycle: IDLE, `dp_reset`=1, no further `sample`.
  - `valid` remains 1 until `ack`.
  - Re-enable: FLUSH, then SETTLE repeats.
- Asynchronous reset in RUN: assert `reset`=0 between clock edges.
  - Outputs go to reset values immediately: `sample`=0, `dp_reset`=1, `valid`=0.
- Watchdog, with `SPEED_SEQ_WATCHDOG_EN` and N=6: hold `dp_ready`=0 in RUN.
  - At the 66th `sample`, `fault`=1 and the FSM passes through FLUSH.
  - Without the macro, `fault` stays 0.
